// File: rtl/axi_pkg.sv
// Shared AXI read-channel types and constants for the CPU wrapper.
package axi_pkg;

  localparam int ID_W    = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 4;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  typedef logic mst_idx_t;
  localparam mst_idx_t MST_M0 = 1'b0;
  localparam mst_idx_t MST_M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic; the priority flop lives in the caller.
module rr_arb2
  import axi_pkg::*;
(
  input  logic [1:0] req,
  input  logic       load,
  input  mst_idx_t   prio,
  output logic [1:0] gnt,
  output mst_idx_t   prio_nxt
);

  always_comb begin
    gnt[0]   = req[0] & ((prio == MST_M0) | ~req[1]);
    gnt[1]   = req[1] & ~gnt[0];
    prio_nxt = prio;
    if (load)
      prio_nxt = gnt[0] ? MST_M1 : MST_M0;
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 AR/R slave port between fetch (M0) and data (M1),
// one outstanding burst at a time, with an RLAST/ARLEN consistency check.
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   ARID_M0,
  input  logic [ADDR_WIDTH-1:0] ARADDR_M0,
  input  logic [3:0]            ARLEN_M0,
  input  logic [2:0]            ARSIZE_M0,
  input  logic [1:0]            ARBURST_M0,
  input  logic                  ARVALID_M0,
  output logic                  ARREADY_M0,
  input  logic [ID_WIDTH-1:0]   ARID_M1,
  input  logic [ADDR_WIDTH-1:0] ARADDR_M1,
  input  logic [3:0]            ARLEN_M1,
  input  logic [2:0]            ARSIZE_M1,
  input  logic [1:0]            ARBURST_M1,
  input  logic                  ARVALID_M1,
  output logic                  ARREADY_M1,
  output logic [ID_WIDTH-1:0]   ARID_S,
  output logic [ADDR_WIDTH-1:0] ARADDR_S,
  output logic [3:0]            ARLEN_S,
  output logic [2:0]            ARSIZE_S,
  output logic [1:0]            ARBURST_S,
  output logic                  ARVALID_S,
  input  logic                  ARREADY_S,
  output logic [ID_WIDTH-1:0]   RID_M0,
  output logic [DATA_WIDTH-1:0] RDATA_M0,
  output logic [1:0]            RRESP_M0,
  output logic                  RLAST_M0,
  output logic                  RVALID_M0,
  input  logic                  RREADY_M0,
  output logic [ID_WIDTH-1:0]   RID_M1,
  output logic [DATA_WIDTH-1:0] RDATA_M1,
  output logic [1:0]            RRESP_M1,
  output logic                  RLAST_M1,
  output logic                  RVALID_M1,
  input  logic                  RREADY_M1,
  input  logic [ID_WIDTH-1:0]   RID_S,
  input  logic [DATA_WIDTH-1:0] RDATA_S,
  input  logic [1:0]            RRESP_S,
  input  logic                  RLAST_S,
  input  logic                  RVALID_S,
  output logic                  RREADY_S,
  output logic                  RLAST_ERR
);

  state_e                state_q, state_d;
  mst_idx_t              prio_q, prio_d;
  mst_idx_t              gsel_q, gsel_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [3:0]            arlen_q, arlen_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [1:0]            arburst_q, arburst_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       load;
  logic       in_data;
  logic       r_hs;

  assign req  = (state_q == ST_IDLE) ? {ARVALID_M1, ARVALID_M0} : 2'b00;
  assign load = |gnt;

  rr_arb2 u_arb (
    .req      (req),
    .load     (load),
    .prio     (prio_q),
    .gnt      (gnt),
    .prio_nxt (prio_d)
  );

  assign ARREADY_M0 = gnt[0];
  assign ARREADY_M1 = gnt[1];

  assign ARVALID_S = (state_q == ST_ADDR);
  assign ARID_S    = arid_q;
  assign ARADDR_S  = araddr_q;
  assign ARLEN_S   = arlen_q;
  assign ARSIZE_S  = arsize_q;
  assign ARBURST_S = arburst_q;

  assign in_data   = (state_q == ST_DATA);
  assign RREADY_S  = in_data & (gsel_q ? RREADY_M1 : RREADY_M0);
  assign RVALID_M0 = in_data & (gsel_q == MST_M0) & RVALID_S;
  assign RVALID_M1 = in_data & (gsel_q == MST_M1) & RVALID_S;
  assign r_hs      = RVALID_S & RREADY_S;

  assign RID_M0   = RID_S;
  assign RDATA_M0 = RDATA_S;
  assign RRESP_M0 = RRESP_S;
  assign RLAST_M0 = RLAST_S;
  assign RID_M1   = RID_S;
  assign RDATA_M1 = RDATA_S;
  assign RRESP_M1 = RRESP_S;
  assign RLAST_M1 = RLAST_S;

  assign RLAST_ERR = err_q;

  always_comb begin
    state_d   = state_q;
    gsel_d    = gsel_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          gsel_d    = gnt[1] ? MST_M1 : MST_M0;
          arid_d    = gnt[1] ? ARID_M1    : ARID_M0;
          araddr_d  = gnt[1] ? ARADDR_M1  : ARADDR_M0;
          arlen_d   = gnt[1] ? ARLEN_M1   : ARLEN_M0;
          arsize_d  = gnt[1] ? ARSIZE_M1  : ARSIZE_M0;
          arburst_d = gnt[1] ? ARBURST_M1 : ARBURST_M0;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (ARREADY_S) begin
          cnt_d   = 4'd0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_hs) begin
          cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
          // Early and missing RLAST both flag; only RLAST_S ends the burst.
          err_d = RLAST_S ? (cnt_q != arlen_q) : (cnt_q == arlen_q);
          if (RLAST_S)
            state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      prio_q    <= MST_M0;
      gsel_q    <= MST_M0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      gsel_q    <= gsel_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized bench for axi_read_arbiter against a transaction-level model.
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ARID_M0, ARID_M1, ARID_S;
  logic [31:0] ARADDR_M0, ARADDR_M1, ARADDR_S;
  logic [3:0]  ARLEN_M0, ARLEN_M1, ARLEN_S;
  logic [2:0]  ARSIZE_M0, ARSIZE_M1, ARSIZE_S;
  logic [1:0]  ARBURST_M0, ARBURST_M1, ARBURST_S;
  logic        ARVALID_M0, ARVALID_M1, ARVALID_S;
  logic        ARREADY_M0, ARREADY_M1, ARREADY_S;
  logic [3:0]  RID_M0, RID_M1, RID_S;
  logic [31:0] RDATA_M0, RDATA_M1, RDATA_S;
  logic [1:0]  RRESP_M0, RRESP_M1, RRESP_S;
  logic        RLAST_M0, RLAST_M1, RLAST_S;
  logic        RVALID_M0, RVALID_M1, RVALID_S;
  logic        RREADY_M0, RREADY_M1, RREADY_S;
  logic        RLAST_ERR;

  int n_chk = 0;
  int n_err = 0;
  int m_prio = 0;

  always #5 clk = ~clk;

  axi_read_arbiter dut (
    .clk(clk), .rst(rst),
    .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0),
    .ARSIZE_M0(ARSIZE_M0), .ARBURST_M0(ARBURST_M0),
    .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
    .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1),
    .ARSIZE_M1(ARSIZE_M1), .ARBURST_M1(ARBURST_M1),
    .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
    .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S),
    .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0),
    .RLAST_M0(RLAST_M0), .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
    .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1),
    .RLAST_M1(RLAST_M1), .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S),
    .RLAST_S(RLAST_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .RLAST_ERR(RLAST_ERR)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ARVALID_M0 = 0; ARVALID_M1 = 0; ARREADY_S = 0;
    RVALID_S = 0; RLAST_S = 0; RREADY_M0 = 0; RREADY_M1 = 0;
    RID_S = 0; RDATA_S = 0; RRESP_S = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    m_prio = 0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_arvalid_s"}, ARVALID_S, 1'b0);
    chk({tag, "_arready_m0"}, ARREADY_M0, 1'b0);
    chk({tag, "_arready_m1"}, ARREADY_M1, 1'b0);
    chk({tag, "_rvalid_m0"}, RVALID_M0, 1'b0);
    chk({tag, "_rvalid_m1"}, RVALID_M1, 1'b0);
    chk({tag, "_rready_s"}, RREADY_S, 1'b0);
    chk({tag, "_rlast_err"}, RLAST_ERR, 1'b0);
  endtask

  // One full transaction: request, optional AR stall, then R beats until
  // the slave's RLAST (beat index last_sel, or ARLEN when last_sel < 0).
  task automatic run_txn(input bit r0, input bit r1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [3:0] l0, input logic [3:0] l1,
                         input int bp, input int last_sel,
                         input logic [31:0] d0, input bit rr_rand,
                         output int gout, output int nbeats);
    int g, last, k, guard;
    logic [3:0] eid, el;
    logic [31:0] ea;
    logic [2:0] es;
    logic [1:0] eb;
    bit err_prev, rr, hs;
    logic [3:0] cm;
    ARID_M0 = 4'($urandom); ARID_M1 = 4'($urandom);
    ARSIZE_M0 = 3'($urandom); ARSIZE_M1 = 3'($urandom);
    ARBURST_M0 = 2'($urandom); ARBURST_M1 = 2'($urandom);
    ARADDR_M0 = a0; ARADDR_M1 = a1;
    ARLEN_M0 = l0; ARLEN_M1 = l1;
    ARVALID_M0 = r0; ARVALID_M1 = r1;
    #1;
    g = (r0 && (m_prio == 0 || !r1)) ? 0 : 1;
    chk("grant_m0", ARREADY_M0, g == 0);
    chk("grant_m1", ARREADY_M1, g == 1);
    m_prio = (g == 0) ? 1 : 0;
    eid = g ? ARID_M1 : ARID_M0;
    ea  = g ? a1 : a0;
    el  = g ? l1 : l0;
    es  = g ? ARSIZE_M1 : ARSIZE_M0;
    eb  = g ? ARBURST_M1 : ARBURST_M0;
    gout = g;
    tick();
    ARVALID_M0 = 1; ARVALID_M1 = 1;
    ARADDR_M0 = $urandom; ARADDR_M1 = $urandom;
    ARLEN_M0 = 4'($urandom); ARLEN_M1 = 4'($urandom);
    ARREADY_S = 0;
    for (int i = 0; i < bp; i++) begin
      #1;
      chk("bp_arvalid_s", ARVALID_S, 1'b1);
      chk("bp_araddr_s", ARADDR_S, ea);
      chk("bp_arready_m0", ARREADY_M0, 1'b0);
      chk("bp_arready_m1", ARREADY_M1, 1'b0);
      tick();
    end
    ARREADY_S = 1;
    #1;
    chk("arvalid_s", ARVALID_S, 1'b1);
    chk("araddr_s", ARADDR_S, ea);
    chk("arid_s", ARID_S, eid);
    chk("arlen_s", ARLEN_S, el);
    chk("arsize_s", ARSIZE_S, es);
    chk("arburst_s", ARBURST_S, eb);
    tick();
    ARREADY_S = 0;
    last = (last_sel < 0) ? int'(el) : last_sel;
    k = 0; guard = 0; err_prev = 0; nbeats = 0;
    while (k <= last && guard < 300) begin
      guard++;
      RVALID_S = ($urandom_range(0, 3) != 0);
      RDATA_S  = (k == 0 && d0 != 0) ? d0 : $urandom;
      RID_S    = 4'($urandom);
      RRESP_S  = 2'($urandom);
      RLAST_S  = (k == last);
      rr = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      RREADY_M0 = g ? 1'($urandom) : rr;
      RREADY_M1 = g ? rr : 1'($urandom);
      #1;
      chk("rlast_err", RLAST_ERR, err_prev);
      chk("rvalid_g", g ? RVALID_M1 : RVALID_M0, RVALID_S);
      chk("rvalid_other", g ? RVALID_M0 : RVALID_M1, 1'b0);
      chk("rready_s", RREADY_S, rr);
      chk("rdata_m0", RDATA_M0, RDATA_S);
      chk("rdata_m1", RDATA_M1, RDATA_S);
      chk("rid_fwd", {RID_M0, RID_M1}, {RID_S, RID_S});
      chk("rresp_fwd", {RRESP_M0, RRESP_M1}, {RRESP_S, RRESP_S});
      chk("rlast_fwd", {RLAST_M0, RLAST_M1}, {RLAST_S, RLAST_S});
      chk("data_arready", {ARREADY_M0, ARREADY_M1}, 2'b00);
      if (k == 0 && d0 != 0 && RVALID_S)
        chk("rdata_fixed", g ? RDATA_M1 : RDATA_M0, d0);
      if (g ? (RVALID_M1 && RREADY_M1) : (RVALID_M0 && RREADY_M0))
        nbeats++;
      hs = RVALID_S && rr;
      if (hs) begin
        cm = (k > 15) ? 4'hF : 4'(k);
        err_prev = RLAST_S ? (cm != el) : (cm == el);
        k++;
      end else begin
        err_prev = 0;
      end
      tick();
    end
    if (guard >= 300)
      chk("beat_budget", 1'b1, 1'b0);
    ARVALID_M0 = 0; ARVALID_M1 = 0;
    RVALID_S = 0; RLAST_S = 0;
    #1;
    chk("rlast_err_end", RLAST_ERR, err_prev);
    chk("end_arvalid_s", ARVALID_S, 1'b0);
    chk("end_rready_s", RREADY_S, 1'b0);
  endtask

  initial begin
    int g, nb;
    int order[4];
    logic [31:0] a;
    bit r0, r1;
    order[0] = 0; order[1] = 1; order[2] = 0; order[3] = 1;

    do_reset();
    #1;
    chk_reset_outs("reset");
    chk("reset_araddr_s", ARADDR_S, 32'h0);

    // single M0 beat, then an immediate follow-up request (IDLE at t+3)
    run_txn(1, 0, 32'h0000_0100, 32'h0, 4'd0, 4'd0, 0, -1,
            32'hDEADBEEF, 0, g, nb);
    chk("single_grant", g, 0);
    chk("single_beats", nb, 1);
    run_txn(1, 0, 32'h0000_0200, 32'h0, 4'd0, 4'd0, 0, -1,
            32'h0, 0, g, nb);
    chk("follow_grant", g, 0);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_txn(1, 1, 32'h1000 + i, 32'h2000 + i, 4'd0, 4'd0, 0, -1,
              32'h0, 0, g, nb);
      chk("rr_order", g, order[i]);
    end

    run_txn(1, 0, 32'h0000_3000, 32'h0, 4'd1, 4'd0, 5, -1,
            32'h0, 0, g, nb);

    run_txn(0, 1, 32'h0, 32'h0000_4000, 4'd0, 4'd3, 1, -1,
            32'h0, 1, g, nb);
    chk("burst4_grant", g, 1);
    chk("burst4_beats", nb, 4);

    run_txn(1, 0, 32'h0000_5000, 32'h0, 4'd3, 4'd0, 0, 1,
            32'h0, 0, g, nb);
    chk("early_beats", nb, 2);

    run_txn(0, 1, 32'h0, 32'h0000_6000, 4'd0, 4'd1, 0, 3,
            32'h0, 0, g, nb);
    chk("late_beats", nb, 4);

    // reset while a 4-beat M0 burst is in DATA
    ARVALID_M0 = 1; ARVALID_M1 = 0; ARLEN_M0 = 4'd3;
    ARADDR_M0 = 32'h0000_7000;
    tick();
    ARVALID_M0 = 0; ARREADY_S = 1;
    tick();
    ARREADY_S = 0; RVALID_S = 1; RLAST_S = 0; RREADY_M0 = 1;
    #1;
    chk("mid_rvalid_m0", RVALID_M0, 1'b1);
    rst = 1;
    tick();
    rst = 0;
    m_prio = 0;
    #1;
    chk_reset_outs("midrst");
    RVALID_S = 0; RREADY_M0 = 0;
    run_txn(1, 1, 32'h0000_8000, 32'h0000_9000, 4'd0, 4'd0, 0, -1,
            32'h0, 0, g, nb);
    chk("midrst_prio", g, 0);

    for (int i = 0; i < 40; i++) begin
      r0 = 1'($urandom); r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1;
      a = $urandom;
      run_txn(r0, r1, a, ~a, 4'($urandom_range(0, 7)),
              4'($urandom_range(0, 7)), $urandom_range(0, 3),
              ($urandom_range(0, 4) == 0) ? $urandom_range(0, 9) : -1,
              32'h0, 1, g, nb);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
